// File: rtl/cmd_reply_buffer_pkg.sv
// cmd_reply_buffer_pkg
//   Shared definitions for the packet-atomic reply buffer:
//   - default packet geometry (words per slot, number of slots)
//   - index / slot / count widths derived from the default geometry
//   - the 16-bit reply word type
//   - a helper that sizes the committed-packet counter for any slot count
package cmd_reply_buffer_pkg;

  localparam int DEF_PKT_WORDS = 256;
  localparam int DEF_NUM_PKTS  = 2;

  localparam int DEF_IDX_W  = $clog2(DEF_PKT_WORDS);
  localparam int DEF_LEN_W  = DEF_IDX_W + 1;
  localparam int DEF_SLOT_W = $clog2(DEF_NUM_PKTS);
  localparam int DEF_CNT_W  = DEF_SLOT_W + 1;

  typedef logic [15:0] word_t;

  // The counter must hold 0..num_pkts inclusive, hence one extra bit.
  function automatic int cnt_width(input int num_pkts);
    return $clog2(num_pkts) + 1;
  endfunction

endpackage

// File: rtl/cmd_reply_buffer_if.sv
// cmd_reply_buffer_if
//   Bundles the write side (command reader) and read side (RX USB path) of
//   the reply buffer.
//   Write side : rx_databus, rx_WR, rx_WR_done in; rx_WR_enabled out
//   Read side  : rd_req in; rd_data, rd_valid, pkt_ready, pkt_count out
//   Status     : overrun out (sticky), clear_status in
//   master = the environment driving the buffer, slave = the buffer itself.
interface cmd_reply_buffer_if
  import cmd_reply_buffer_pkg::*;
#(
  parameter int NUM_PKTS = DEF_NUM_PKTS
);

  localparam int CNT_W = cnt_width(NUM_PKTS);

  word_t            rx_databus;
  logic             rx_WR;
  logic             rx_WR_done;
  logic             rx_WR_enabled;
  logic             rd_req;
  word_t            rd_data;
  logic             rd_valid;
  logic             pkt_ready;
  logic [CNT_W-1:0] pkt_count;
  logic             overrun;
  logic             clear_status;

  modport master (
    output rx_databus, rx_WR, rx_WR_done, rd_req, clear_status,
    input  rx_WR_enabled, rd_data, rd_valid, pkt_ready, pkt_count, overrun
  );

  modport slave (
    input  rx_databus, rx_WR, rx_WR_done, rd_req, clear_status,
    output rx_WR_enabled, rd_data, rd_valid, pkt_ready, pkt_count, overrun
  );

endinterface

// File: rtl/cmd_reply_ram.sv
// cmd_reply_ram
//   Simple dual-port storage for all packet slots, addressed as {slot, idx}.
//   Ports:
//     txclk        - clock
//     we/waddr/wdata - write port, written on the rising edge
//     re/raddr     - read request and address
//     rdata        - registered read data, updated only when re is high
//   Contents are never reset.
module cmd_reply_ram
  import cmd_reply_buffer_pkg::*;
#(
  parameter int ADDR_W = DEF_SLOT_W + DEF_IDX_W
) (
  input  logic              txclk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  word_t             wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output word_t             rdata
);

  word_t mem [2**ADDR_W];

  always_ff @(posedge txclk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge txclk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/cmd_reply_buffer.sv
// cmd_reply_buffer
//   Packet-atomic reply buffer between the TX command reader and the RX USB
//   packet path. Reply words are written into the current fill slot and
//   committed as one fixed-size packet on rx_WR_done; committed packets are
//   read back as exactly PKT_WORDS words each, one word per accepted rd_req,
//   with one cycle of read latency.
//   Ports:
//     txclk - clock (rising edge)
//     reset - synchronous, active-high
//     bus   - cmd_reply_buffer_if.slave (write side, read side, status)
//   Configuration macro: CMD_REPLY_ZERO_PAD_EN
//     defined   - words past a packet's committed length read as 16'h0000
//     undefined - tail words return whatever stale RAM contents remain
module cmd_reply_buffer
  import cmd_reply_buffer_pkg::*;
#(
  parameter int PKT_WORDS = DEF_PKT_WORDS,
  parameter int NUM_PKTS  = DEF_NUM_PKTS
) (
  input  logic                txclk,
  input  logic                reset,
  cmd_reply_buffer_if.slave   bus
);

  localparam int IDX_W  = $clog2(PKT_WORDS);
  localparam int LEN_W  = IDX_W + 1;
  localparam int SLOT_W = $clog2(NUM_PKTS);
  localparam int CNT_W  = cnt_width(NUM_PKTS);
  localparam int ADDR_W = SLOT_W + IDX_W;

  logic [SLOT_W-1:0] wr_slot;
  logic [LEN_W-1:0]  wr_idx;
  logic [SLOT_W-1:0] rd_slot;
  logic [IDX_W-1:0]  rd_idx;
  logic [CNT_W-1:0]  pkt_count;
  logic [LEN_W-1:0]  len [NUM_PKTS];
  logic              overrun;
  logic              rd_valid;
  word_t             ram_q;

  logic              wr_enabled;
  logic              pkt_ready;
  logic              wr_accept;
  logic              wr_drop;
  logic [LEN_W-1:0]  eff_len;
  logic              commit;
  logic              rd_accept;
  logic              rd_last;

  // Handshake decisions. wr_idx can reach PKT_WORDS, at which point the slot
  // is full and further words are dropped until the packet is committed.
  // The effective length counts a word accepted in the same cycle as the
  // commit pulse, so a done-with-last-word reply keeps that word.
  assign wr_enabled = (pkt_count < CNT_W'(NUM_PKTS));
  assign pkt_ready  = (pkt_count != '0);
  assign wr_accept  = bus.rx_WR && wr_enabled && (wr_idx < LEN_W'(PKT_WORDS));
  assign wr_drop    = bus.rx_WR && !wr_accept;
  assign eff_len    = wr_idx + LEN_W'(wr_accept);
  assign commit     = bus.rx_WR_done && (eff_len != '0);
  assign rd_accept  = bus.rd_req && pkt_ready;
  assign rd_last    = rd_accept && (rd_idx == IDX_W'(PKT_WORDS - 1));

  // Fill pointer: the slot advances on commit and the index restarts, which
  // also discards nothing since the committed words stay in RAM.
  always_ff @(posedge txclk) begin
    if (reset) begin
      wr_slot <= '0;
      wr_idx  <= '0;
    end else if (commit) begin
      wr_slot <= wr_slot + SLOT_W'(1);
      wr_idx  <= '0;
    end else if (wr_accept) begin
      wr_idx  <= wr_idx + LEN_W'(1);
    end
  end

  // Per-slot committed length, used for tail padding when enabled.
  always_ff @(posedge txclk) begin
    if (!reset && commit) begin
      len[wr_slot] <= eff_len;
    end
  end

  // Read pointer: every packet is streamed as exactly PKT_WORDS words, so
  // the index wraps naturally and the slot advances on the final word.
  always_ff @(posedge txclk) begin
    if (reset) begin
      rd_slot <= '0;
      rd_idx  <= '0;
    end else if (rd_accept) begin
      rd_idx <= rd_idx + IDX_W'(1);
      if (rd_last) begin
        rd_slot <= rd_slot + SLOT_W'(1);
      end
    end
  end

  // Committed-packet count; a commit and a release in the same cycle cancel.
  always_ff @(posedge txclk) begin
    if (reset) begin
      pkt_count <= '0;
    end else begin
      case ({commit, rd_last})
        2'b10:   pkt_count <= pkt_count + CNT_W'(1);
        2'b01:   pkt_count <= pkt_count - CNT_W'(1);
        default: pkt_count <= pkt_count;
      endcase
    end
  end

  // Read valid follows the accepted request by one cycle, matching the
  // registered RAM output. clear_status wins over a same-cycle dropped write.
  always_ff @(posedge txclk) begin
    if (reset) begin
      rd_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      rd_valid <= rd_accept;
      if (bus.clear_status) begin
        overrun <= 1'b0;
      end else if (wr_drop) begin
        overrun <= 1'b1;
      end
    end
  end

  cmd_reply_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .txclk (txclk),
    .we    (wr_accept),
    .waddr ({wr_slot, wr_idx[IDX_W-1:0]}),
    .wdata (bus.rx_databus),
    .re    (rd_accept),
    .raddr ({rd_slot, rd_idx}),
    .rdata (ram_q)
  );

`ifdef CMD_REPLY_ZERO_PAD_EN
  logic pad_q;

  // The pad decision is captured on the same edge as the RAM read so it
  // lines up with ram_q.
  always_ff @(posedge txclk) begin
    if (reset) begin
      pad_q <= 1'b0;
    end else if (rd_accept) begin
      pad_q <= ({1'b0, rd_idx} >= len[rd_slot]);
    end
  end

  // Output is held at zero whenever no word is being presented.
  assign bus.rd_data = (rd_valid && !pad_q) ? ram_q : '0;
`else
  logic unused_len;

  // Lengths are still tracked but not consulted in this build.
  always_comb begin
    unused_len = 1'b0;
    for (int s = 0; s < NUM_PKTS; s++) begin
      unused_len = unused_len ^ (^len[s]);
    end
  end

  // Output is held at zero whenever no word is being presented.
  assign bus.rd_data = rd_valid ? ram_q : '0;
`endif

  assign bus.rx_WR_enabled = wr_enabled;
  assign bus.rd_valid      = rd_valid;
  assign bus.pkt_ready     = pkt_ready;
  assign bus.pkt_count     = pkt_count;
  assign bus.overrun       = overrun;

endmodule

// File: tb/tb_cmd_reply_buffer.sv
// tb_cmd_reply_buffer
//   Directed bench for cmd_reply_buffer. Stimulus tasks push the expected
//   read words into a scoreboard queue; an independent monitor pops and
//   compares each time rd_valid is seen. Status outputs are checked inline.
module tb_cmd_reply_buffer;
  import cmd_reply_buffer_pkg::*;

  localparam int PKT_WORDS = 256;
  localparam int NUM_PKTS  = 2;

  typedef struct packed {
    logic  care;
    word_t data;
  } exp_t;

  logic txclk = 1'b0;
  logic reset;
  exp_t expQ [$];
  int   compared   = 0;
  int   mismatched = 0;

  always #5 txclk = ~txclk;

  cmd_reply_buffer_if #(.NUM_PKTS(NUM_PKTS)) bus ();

  cmd_reply_buffer #(
    .PKT_WORDS (PKT_WORDS),
    .NUM_PKTS  (NUM_PKTS)
  ) dut (
    .txclk (txclk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge txclk) begin
    exp_t e;
    if (bus.rd_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_rd_valid: got rd_valid=1 data=0x%0h, expected no read at %0t",
                 bus.rd_data, $time);
      end else begin
        e = expQ.pop_front();
        if (e.care) begin
          checkOutput("rd_data", 32'(bus.rd_data), 32'(e.data));
        end
      end
    end
  end

  function automatic exp_t padExp();
    exp_t e;
    e.data = 16'h0000;
`ifdef CMD_REPLY_ZERO_PAD_EN
    e.care = 1'b1;
`else
    e.care = 1'b0;
`endif
    return e;
  endfunction

  function automatic exp_t dataExp(input word_t d);
    exp_t e;
    e.care = 1'b1;
    e.data = d;
    return e;
  endfunction

  // One clock of stimulus; inputs return to idle afterwards.
  task automatic applyStimulus(input logic wr, input word_t data, input logic done,
                               input logic req, input logic clr);
    bus.rx_WR        = wr;
    bus.rx_databus   = data;
    bus.rx_WR_done   = done;
    bus.rd_req       = req;
    bus.clear_status = clr;
    @(posedge txclk);
    #1;
    bus.rx_WR        = 1'b0;
    bus.rx_databus   = 16'h0000;
    bus.rx_WR_done   = 1'b0;
    bus.rd_req       = 1'b0;
    bus.clear_status = 1'b0;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
  endtask

  // Writes n words base+i; commits either with the last word or separately.
  task automatic writePacket(input word_t base, input int n, input bit doneWithLast,
                             input bit doCommit);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, word_t'(base + i),
                    (doCommit && doneWithLast && i == n - 1), 1'b0, 1'b0);
    end
    if (doCommit && !doneWithLast) begin
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    end
  endtask

  // Reads one full packet back-to-back; doneAt>=0 also pulses rx_WR_done on
  // that read cycle.
  task automatic readPacket(input word_t base, input int n, input int doneAt);
    for (int i = 0; i < PKT_WORDS; i++) begin
      if (i < n) expQ.push_back(dataExp(word_t'(base + i)));
      else       expQ.push_back(padExp());
      applyStimulus(1'b0, 16'h0000, (i == doneAt), 1'b1, 1'b0);
    end
  endtask

  initial begin
    bus.rx_WR        = 1'b0;
    bus.rx_databus   = 16'h0000;
    bus.rx_WR_done   = 1'b0;
    bus.rd_req       = 1'b0;
    bus.clear_status = 1'b0;
    reset            = 1'b1;
    repeat (3) @(posedge txclk);
    #1;
    reset = 1'b0;

    // Reset state
    checkOutput("reset_pkt_count", 32'(bus.pkt_count), 0);
    checkOutput("reset_pkt_ready", 32'(bus.pkt_ready), 0);
    checkOutput("reset_wr_enabled", 32'(bus.rx_WR_enabled), 1);
    checkOutput("reset_overrun", 32'(bus.overrun), 0);
    checkOutput("reset_rd_valid", 32'(bus.rd_valid), 0);
    checkOutput("reset_rd_data", 32'(bus.rd_data), 0);

    // Single three-word reply
    applyStimulus(1'b1, 16'hA001, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hA002, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hA003, 1'b0, 1'b0, 1'b0);
    checkOutput("uncommitted_pkt_ready", 32'(bus.pkt_ready), 0);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    checkOutput("single_pkt_ready", 32'(bus.pkt_ready), 1);
    checkOutput("single_pkt_count", 32'(bus.pkt_count), 1);
    readPacket(16'hA001, 3, -1);
    checkOutput("single_drained_count", 32'(bus.pkt_count), 0);
    idle();

    // Fill both slots, then a dropped write
    writePacket(16'h1000, 10, 1'b0, 1'b1);
    writePacket(16'h2000, 10, 1'b0, 1'b1);
    checkOutput("full_pkt_count", 32'(bus.pkt_count), 2);
    checkOutput("full_wr_enabled", 32'(bus.rx_WR_enabled), 0);
    applyStimulus(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0);
    checkOutput("full_overrun", 32'(bus.overrun), 1);
    readPacket(16'h1000, 10, -1);
    checkOutput("release_wr_enabled", 32'(bus.rx_WR_enabled), 1);
    checkOutput("release_pkt_count", 32'(bus.pkt_count), 1);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    checkOutput("clear_overrun", 32'(bus.overrun), 0);
    readPacket(16'h2000, 10, -1);
    idle();
    // Dropped word must not have advanced the fill index
    writePacket(16'h3000, 1, 1'b0, 1'b1);
    readPacket(16'h3000, 1, -1);
    idle();

    // Oversize reply: 260 words, only 256 kept
    writePacket(16'h4000, 260, 1'b0, 1'b0);
    checkOutput("oversize_overrun", 32'(bus.overrun), 1);
    checkOutput("oversize_no_commit", 32'(bus.pkt_count), 0);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    checkOutput("oversize_pkt_count", 32'(bus.pkt_count), 1);
    readPacket(16'h4000, 256, -1);
    idle();
    // clear_status beats a simultaneous dropped write (buffer full there is
    // not the case, so overflow a slot again is unnecessary: overrun is
    // still set from the oversize reply)
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    checkOutput("oversize_clear", 32'(bus.overrun), 0);
    writePacket(16'hC000, 2, 1'b0, 1'b1);
    writePacket(16'hC100, 2, 1'b0, 1'b1);
    applyStimulus(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b1);
    checkOutput("clear_priority", 32'(bus.overrun), 0);
    readPacket(16'hC000, 2, -1);
    readPacket(16'hC100, 2, -1);
    idle();

    // Word written in the same cycle as the commit is kept
    writePacket(16'h5000, 5, 1'b1, 1'b1);
    checkOutput("wr_with_done_count", 32'(bus.pkt_count), 1);
    // Commit of the next reply coincides with the last read of this one
    writePacket(16'h6000, 2, 1'b0, 1'b0);
    readPacket(16'h5000, 5, PKT_WORDS - 1);
    checkOutput("commit_release_count", 32'(bus.pkt_count), 1);
    readPacket(16'h6000, 2, -1);
    idle();
    checkOutput("after_simul_count", 32'(bus.pkt_count), 0);

    // Empty commit is ignored; reads with nothing ready produce nothing
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    checkOutput("empty_done_count", 32'(bus.pkt_count), 0);
    checkOutput("empty_done_ready", 32'(bus.pkt_ready), 0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    idle();
    writePacket(16'h7000, 1, 1'b1, 1'b1);
    readPacket(16'h7000, 1, -1);
    idle();

    // Reset in the middle of reading and filling
    writePacket(16'h8000, 3, 1'b0, 1'b1);
    writePacket(16'h9000, 2, 1'b0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      if (i < 3) expQ.push_back(dataExp(word_t'(16'h8000 + i)));
      else       expQ.push_back(padExp());
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    end
    idle();
    reset = 1'b1;
    @(posedge txclk);
    #1;
    reset = 1'b0;
    checkOutput("midreset_pkt_count", 32'(bus.pkt_count), 0);
    checkOutput("midreset_wr_enabled", 32'(bus.rx_WR_enabled), 1);
    checkOutput("midreset_rd_valid", 32'(bus.rd_valid), 0);
    checkOutput("midreset_pkt_ready", 32'(bus.pkt_ready), 0);
    writePacket(16'hB000, 2, 1'b0, 1'b1);
    readPacket(16'hB000, 2, -1);
    idle();
    idle();

    checkOutput("final_pkt_count", 32'(bus.pkt_count), 0);
    checkOutput("scoreboard_empty", 32'(expQ.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
